// File: rtl/int_wb_arbiter.sv
// Integer writeback arbiter: per-source result FIFOs drained round-robin
// onto two registered writeback ports, with ROB-flush squashing.
module int_wb_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int FIFO_DEPTH  = 2,
    parameter int DATA_WIDTH  = 64,
    parameter int PREG_WIDTH  = 6,
    parameter int ROBID_WIDTH = 7
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC-1:0]             src_need_to_wb,
    input  logic [NUM_SRC*PREG_WIDTH-1:0]  src_prd,
    input  logic [NUM_SRC*ROBID_WIDTH-1:0] src_robid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  src_result,
    input  logic                           flush_valid,
    input  logic [ROBID_WIDTH-1:0]         flush_robid,
    output logic                           writeback0_valid,
    output logic                           writeback0_need_to_wb,
    output logic [PREG_WIDTH-1:0]          writeback0_prd,
    output logic [ROBID_WIDTH-1:0]         writeback0_robid,
    output logic [DATA_WIDTH-1:0]          writeback0_data,
    output logic                           writeback1_valid,
    output logic                           writeback1_need_to_wb,
    output logic [PREG_WIDTH-1:0]          writeback1_prd,
    output logic [ROBID_WIDTH-1:0]         writeback1_robid,
    output logic [DATA_WIDTH-1:0]          writeback1_data
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                   need;
        logic [PREG_WIDTH-1:0]  prd;
        logic [ROBID_WIDTH-1:0] robid;
        logic [DATA_WIDTH-1:0]  data;
    } ent_t;

    ent_t          ent_q [NUM_SRC][FIFO_DEPTH];
    ent_t          ent_d [NUM_SRC][FIFO_DEPTH];
    logic [CW-1:0] cnt_q [NUM_SRC];
    logic [CW-1:0] cnt_d [NUM_SRC];
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] rr_d;
    logic [SW-1:0] g0;
    logic [SW-1:0] g1;
    logic          g0_v;
    logic          g1_v;
    logic [NUM_SRC-1:0] pop;
    ent_t          wb0_d;
    ent_t          wb1_d;
    ent_t          wb0_q;
    ent_t          wb1_q;
    logic          wb0_v;
    logic          wb1_v;

    // Wrap bit differs => index order is inverted; equal ids are not younger.
    function automatic logic younger(input logic [ROBID_WIDTH-1:0] a,
                                     input logic [ROBID_WIDTH-1:0] b);
        if (a[ROBID_WIDTH-1] == b[ROBID_WIDTH-1])
            return a[ROBID_WIDTH-2:0] > b[ROBID_WIDTH-2:0];
        return a[ROBID_WIDTH-2:0] < b[ROBID_WIDTH-2:0];
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++)
            src_ready[i] = !reset && (cnt_q[i] < CW'(FIFO_DEPTH));
    end

    always_comb begin : arb
        logic [NUM_SRC-1:0] cand;
        g0_v = 1'b0;
        g1_v = 1'b0;
        g0   = '0;
        g1   = '0;
        for (int i = 0; i < NUM_SRC; i++)
            cand[i] = (cnt_q[i] != '0) &&
                      !(flush_valid && younger(ent_q[i][0].robid, flush_robid));
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i == (int'(rr_ptr) + k) % NUM_SRC && cand[i]) begin
                    if (!g0_v) begin
                        g0_v = 1'b1;
                        g0   = SW'(i);
                    end else if (!g1_v) begin
                        g1_v = 1'b1;
                        g1   = SW'(i);
                    end
                end
            end
        end
    end

    always_comb begin : sel
        wb0_d = '0;
        wb1_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = (g0_v && g0 == SW'(i)) || (g1_v && g1 == SW'(i));
            if (g0_v && g0 == SW'(i))
                wb0_d = ent_q[i][0];
            if (g1_v && g1 == SW'(i))
                wb1_d = ent_q[i][0];
        end
        rr_d = rr_ptr;
        if (g1_v)
            rr_d = SW'((int'(g1) + 1) % NUM_SRC);
        else if (g0_v)
            rr_d = SW'((int'(g0) + 1) % NUM_SRC);
    end

    // Pop the head, drop flushed entries, compact survivors, then append.
    always_comb begin : fifo_next
        int   n;
        ent_t in_e;
        for (int i = 0; i < NUM_SRC; i++) begin
            n = 0;
            for (int k = 0; k < FIFO_DEPTH; k++)
                ent_d[i][k] = ent_q[i][k];
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                if (j < int'(cnt_q[i]) && !(j == 0 && pop[i]) &&
                    !(flush_valid && younger(ent_q[i][j].robid, flush_robid))) begin
                    for (int k = 0; k < FIFO_DEPTH; k++)
                        if (k == n)
                            ent_d[i][k] = ent_q[i][j];
                    n++;
                end
            end
            in_e.need  = src_need_to_wb[i];
            in_e.prd   = src_prd[i*PREG_WIDTH +: PREG_WIDTH];
            in_e.robid = src_robid[i*ROBID_WIDTH +: ROBID_WIDTH];
            in_e.data  = src_result[i*DATA_WIDTH +: DATA_WIDTH];
            if (src_valid[i] && src_ready[i] &&
                !(flush_valid && younger(in_e.robid, flush_robid))) begin
                for (int k = 0; k < FIFO_DEPTH; k++)
                    if (k == n)
                        ent_d[i][k] = in_e;
                n++;
            end
            cnt_d[i] = CW'(n);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SRC; i++)
                cnt_q[i] <= '0;
            rr_ptr <= '0;
            wb0_v  <= 1'b0;
            wb1_v  <= 1'b0;
            wb0_q  <= '0;
            wb1_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                cnt_q[i] <= cnt_d[i];
            rr_ptr <= rr_d;
            wb0_v  <= g0_v;
            wb1_v  <= g1_v;
            wb0_q  <= wb0_d;
            wb1_q  <= wb1_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = 0; k < FIFO_DEPTH; k++)
                ent_q[i][k] <= ent_d[i][k];
    end

    assign writeback0_valid      = wb0_v;
    assign writeback0_need_to_wb = wb0_q.need;
    assign writeback0_prd        = wb0_q.prd;
    assign writeback0_robid      = wb0_q.robid;
    assign writeback0_data       = wb0_q.data;
    assign writeback1_valid      = wb1_v;
    assign writeback1_need_to_wb = wb1_q.need;
    assign writeback1_prd        = wb1_q.prd;
    assign writeback1_robid      = wb1_q.robid;
    assign writeback1_data       = wb1_q.data;

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Bench for int_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic checked against a queue-based model.
module tb_int_wb_arbiter;

    localparam int NS = 4;
    localparam int D  = 2;
    localparam int DW = 64;
    localparam int PW = 6;
    localparam int RW = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    sv;
    logic [NS-1:0]    sneed;
    logic [NS*PW-1:0] sprd;
    logic [NS*RW-1:0] srob;
    logic [NS*DW-1:0] sdat;
    logic             fv;
    logic [RW-1:0]    frob;
    logic [NS-1:0]    src_ready;
    logic             writeback0_valid;
    logic             writeback0_need_to_wb;
    logic [PW-1:0]    writeback0_prd;
    logic [RW-1:0]    writeback0_robid;
    logic [DW-1:0]    writeback0_data;
    logic             writeback1_valid;
    logic             writeback1_need_to_wb;
    logic [PW-1:0]    writeback1_prd;
    logic [RW-1:0]    writeback1_robid;
    logic [DW-1:0]    writeback1_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    typedef struct {
        bit        need;
        int        prd;
        int        robid;
        bit [63:0] data;
    } rec_t;

    rec_t q [NS][$];
    int   rr;
    bit   e0v;
    bit   e1v;
    rec_t e0;
    rec_t e1;

    int_wb_arbiter dut (
        .clock                 (clk),
        .reset                 (rst),
        .src_valid             (sv),
        .src_ready             (src_ready),
        .src_need_to_wb        (sneed),
        .src_prd               (sprd),
        .src_robid             (srob),
        .src_result            (sdat),
        .flush_valid           (fv),
        .flush_robid           (frob),
        .writeback0_valid      (writeback0_valid),
        .writeback0_need_to_wb (writeback0_need_to_wb),
        .writeback0_prd        (writeback0_prd),
        .writeback0_robid      (writeback0_robid),
        .writeback0_data       (writeback0_data),
        .writeback1_valid      (writeback1_valid),
        .writeback1_need_to_wb (writeback1_need_to_wb),
        .writeback1_prd        (writeback1_prd),
        .writeback1_robid      (writeback1_robid),
        .writeback1_data       (writeback1_data)
    );

    always #5 clk = ~clk;

    // Ids live on a circle of 2^RW; younger means up to half a lap ahead.
    function automatic bit tb_younger(int a, int b);
        int d;
        d = (a - b) & ((1 << RW) - 1);
        return d > 0 && d < (1 << (RW - 1));
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        sv    = '0;
        sneed = '0;
        sprd  = '0;
        srob  = '0;
        sdat  = '0;
        fv    = 1'b0;
        frob  = '0;
    endtask

    task automatic drive(int i, int rob, int prd, logic [63:0] d, bit nd);
        sv[i]             = 1'b1;
        sneed[i]          = nd;
        sprd[i*PW +: PW]  = PW'(prd);
        srob[i*RW +: RW]  = RW'(rob);
        sdat[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        tick();
        rst = 1'b0;
    endtask

    always @(posedge clk) begin : model
        int   gs [2];
        int   ng;
        int   s;
        bit   rdy;
        rec_t r;
        rec_t kept [$];
        if (rst) begin
            for (int i = 0; i < NS; i++)
                q[i].delete();
            rr  = 0;
            e0v = 1'b0;
            e1v = 1'b0;
            e0  = '{need: 0, prd: 0, robid: 0, data: 0};
            e1  = '{need: 0, prd: 0, robid: 0, data: 0};
        end else begin
            ng = 0;
            for (int k = 0; k < NS; k++) begin
                s = (rr + k) % NS;
                if (ng < 2 && q[s].size() > 0 &&
                    !(fv && tb_younger(q[s][0].robid, int'(frob)))) begin
                    gs[ng] = s;
                    ng++;
                end
            end
            e0v = ng > 0;
            e1v = ng > 1;
            e0  = '{need: 0, prd: 0, robid: 0, data: 0};
            e1  = '{need: 0, prd: 0, robid: 0, data: 0};
            if (ng > 0)
                e0 = q[gs[0]][0];
            if (ng > 1)
                e1 = q[gs[1]][0];
            if (ng > 0)
                rr = (gs[ng-1] + 1) % NS;
            for (int i = 0; i < NS; i++) begin
                rdy = q[i].size() < D;
                if ((ng > 0 && gs[0] == i) || (ng > 1 && gs[1] == i))
                    void'(q[i].pop_front());
                if (fv) begin
                    kept.delete();
                    for (int j = 0; j < q[i].size(); j++)
                        if (!tb_younger(q[i][j].robid, int'(frob)))
                            kept.push_back(q[i][j]);
                    q[i] = kept;
                end
                r.need  = sneed[i];
                r.prd   = int'(sprd[i*PW +: PW]);
                r.robid = int'(srob[i*RW +: RW]);
                r.data  = sdat[i*DW +: DW];
                if (sv[i] && rdy && !(fv && tb_younger(r.robid, int'(frob))))
                    q[i].push_back(r);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NS-1:0] er;
        if (started) begin
            for (int i = 0; i < NS; i++)
                er[i] = !rst && (q[i].size() < D);
            chk("src_ready", 64'(src_ready), 64'(er));
            chk("wb0_valid", 64'(writeback0_valid), 64'(e0v));
            chk("wb0_need", 64'(writeback0_need_to_wb), 64'(e0.need));
            chk("wb0_prd", 64'(writeback0_prd), 64'(e0.prd));
            chk("wb0_robid", 64'(writeback0_robid), 64'(e0.robid));
            chk("wb0_data", writeback0_data, e0.data);
            chk("wb1_valid", 64'(writeback1_valid), 64'(e1v));
            chk("wb1_need", 64'(writeback1_need_to_wb), 64'(e1.need));
            chk("wb1_prd", 64'(writeback1_prd), 64'(e1.prd));
            chk("wb1_robid", 64'(writeback1_robid), 64'(e1.robid));
            chk("wb1_data", writeback1_data, e1.data);
            chk("wb1_implies_wb0", 64'(writeback1_valid & ~writeback0_valid), 64'd0);
        end
    end

    initial begin
        rst = 1'b1;
        clr();
        tick();
        started = 1'b1;
        tick();
        chk("rst_wb0_valid", 64'(writeback0_valid), 64'd0);
        chk("rst_wb1_valid", 64'(writeback1_valid), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(src_ready), 64'hF);

        // single result, two-cycle latency
        do_reset();
        drive(0, 3, 5, 64'hAB, 1'b1);
        tick();
        clr();
        tick();
        chk("single_v0", 64'(writeback0_valid), 64'd1);
        chk("single_prd", 64'(writeback0_prd), 64'd5);
        chk("single_rob", 64'(writeback0_robid), 64'd3);
        chk("single_data", writeback0_data, 64'hAB);
        chk("single_v1", 64'(writeback1_valid), 64'd0);

        // contention, then rr_ptr back at 0
        do_reset();
        for (int i = 0; i < NS; i++)
            drive(i, 20 + i, i, 64'(100 + i), 1'b1);
        tick();
        clr();
        tick();
        chk("cont_a_rob0", 64'(writeback0_robid), 64'd20);
        chk("cont_a_rob1", 64'(writeback1_robid), 64'd21);
        tick();
        chk("cont_b_rob0", 64'(writeback0_robid), 64'd22);
        chk("cont_b_rob1", 64'(writeback1_robid), 64'd23);
        drive(0, 30, 1, 64'h30, 1'b0);
        drive(3, 33, 2, 64'h33, 1'b1);
        tick();
        clr();
        tick();
        chk("rr_wrap_rob0", 64'(writeback0_robid), 64'd30);
        chk("rr_wrap_rob1", 64'(writeback1_robid), 64'd33);
        chk("rr_wrap_need0", 64'(writeback0_need_to_wb), 64'd0);

        // back-pressure on the later sources
        do_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NS; i++)
                drive(i, 40 + 4 * c + i, i + 8, 64'(c * 16 + i), 1'b1);
            tick();
            if (c == 1) begin
                chk("bp_ready", 64'(src_ready), 64'h3);
                chk("bp_rob0", 64'(writeback0_robid), 64'd40);
                chk("bp_rob1", 64'(writeback1_robid), 64'd41);
            end
        end
        clr();
        repeat (6) tick();

        // flush kills younger, spares equal, drops incoming younger
        do_reset();
        drive(0, 10, 1, 64'h10, 1'b1);
        drive(1, 12, 2, 64'h12, 1'b1);
        drive(2, 14, 3, 64'h14, 1'b1);
        tick();
        clr();
        fv   = 1'b1;
        frob = 7'd12;
        drive(3, 13, 4, 64'h13, 1'b1);
        tick();
        chk("flush_v0", 64'(writeback0_valid), 64'd1);
        chk("flush_rob0", 64'(writeback0_robid), 64'd10);
        chk("flush_v1", 64'(writeback1_valid), 64'd1);
        chk("flush_rob1", 64'(writeback1_robid), 64'd12);
        clr();
        tick();
        chk("flush_after_v0", 64'(writeback0_valid), 64'd0);
        chk("flush_after_v1", 64'(writeback1_valid), 64'd0);

        // flush across the wrap bit
        do_reset();
        drive(0, 60, 7, 64'h60, 1'b1);
        drive(1, 64 + 5, 9, 64'h69, 1'b1);
        tick();
        clr();
        fv   = 1'b1;
        frob = 7'(64 + 2);
        tick();
        chk("wrap_v0", 64'(writeback0_valid), 64'd1);
        chk("wrap_rob0", 64'(writeback0_robid), 64'd60);
        chk("wrap_v1", 64'(writeback1_valid), 64'd0);
        clr();
        tick();
        chk("wrap_after_v0", 64'(writeback0_valid), 64'd0);

        // reset while entries are buffered
        do_reset();
        drive(0, 50, 1, 64'h1, 1'b1);
        drive(1, 51, 2, 64'h2, 1'b1);
        drive(2, 52, 3, 64'h3, 1'b1);
        tick();
        rst = 1'b1;
        clr();
        #1;
        chk("midrst_ready", 64'(src_ready), 64'd0);
        tick();
        chk("midrst_v0", 64'(writeback0_valid), 64'd0);
        chk("midrst_v1", 64'(writeback1_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("midrst_after_v0", 64'(writeback0_valid), 64'd0);
        chk("midrst_after_ready", 64'(src_ready), 64'hF);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 199) == 0);
            fv   = ($urandom_range(0, 7) == 0);
            frob = RW'($urandom);
            for (int i = 0; i < NS; i++) begin
                sv[i]            = ($urandom_range(0, 3) != 0);
                sneed[i]         = 1'($urandom_range(0, 1));
                sprd[i*PW +: PW] = PW'($urandom);
                srob[i*RW +: RW] = RW'($urandom);
                sdat[i*DW +: DW] = {$urandom, $urandom};
            end
            tick();
        end
        rst = 1'b0;
        clr();
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
